// File: rtl/axil_cmd_master_if.sv
// AXI-Lite bus bundle between the command master and its slave.
// The master modport drives addresses, data, valids and response readies.
interface axil_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] aw_addr;
  logic              aw_valid;
  logic              aw_ready;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              w_valid;
  logic              w_ready;
  logic [1:0]        b_resp;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic              ar_valid;
  logic              ar_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic              r_valid;
  logic              r_ready;

  modport master (
    output aw_addr, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid, input w_ready,
    input b_resp, b_valid, output b_ready,
    output ar_addr, ar_valid, input ar_ready,
    input r_data, r_resp, r_valid, output r_ready
  );

  modport slave (
    input aw_addr, aw_valid, output aw_ready,
    input w_data, w_strb, w_valid, output w_ready,
    output b_resp, b_valid, input b_ready,
    input ar_addr, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid, input r_ready
  );
endinterface

// File: rtl/axil_cmd_master.sv
// Scripted AXI-Lite master: one transaction per command, read-back compare,
// one result per command, saturating pass/fail counters, halt after a timeout.
module axil_cmd_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic [DATA_W-1:0]      cmd_data,
  input  logic [DATA_W-1:0]      cmd_mask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [1:0]             rsp_resp,
  output logic                   rsp_mismatch,
  output logic                   rsp_timeout,
  axil_cmd_master_if.master      axil,
  output logic [CNT_W-1:0]       cmd_count,
  output logic [CNT_W-1:0]       err_count,
  output logic                   halted
);
  localparam int          STRB_W    = DATA_W / 8;
  localparam bit          TMO_EN    = (TIMEOUT != 0);
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WR_B = 3'd2,
    S_RD_A = 3'd3,
    S_RD_R = 3'd4,
    S_RSP  = 3'd5,
    S_HALT = 3'd6
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic cmp_fail(input logic [DATA_W-1:0] got,
                                    input logic [DATA_W-1:0] exp,
                                    input logic [DATA_W-1:0] mask);
    return |((got ^ exp) & mask);
  endfunction

  state_t            state_q, state_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              aw_valid_q, aw_valid_d;
  logic              w_valid_q, w_valid_d;
  logic              b_ready_q, b_ready_d;
  logic              ar_valid_q, ar_valid_d;
  logic              r_ready_q, r_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic              rsp_mismatch_q, rsp_mismatch_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  cmd_count_q, cmd_count_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              halted_q, halted_d;

  logic aw_hs_s, w_hs_s, tmo_hit_s, abort_s;

  // Next-state and registered-output computation.
  always_comb begin
    state_d        = state_q;
    wr_d           = wr_q;
    addr_d         = addr_q;
    data_d         = data_q;
    mask_d         = mask_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    tmo_d          = TMO_EN ? (tmo_q + 32'd1) : tmo_q;
    aw_valid_d     = aw_valid_q;
    w_valid_d      = w_valid_q;
    b_ready_d      = b_ready_q;
    ar_valid_d     = ar_valid_q;
    r_ready_d      = r_ready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_write_d    = rsp_write_q;
    rsp_data_d     = rsp_data_q;
    rsp_resp_d     = rsp_resp_q;
    rsp_mismatch_d = rsp_mismatch_q;
    rsp_timeout_d  = rsp_timeout_q;
    cmd_count_d    = cmd_count_q;
    err_count_d    = err_count_q;
    abort_s        = 1'b0;
    aw_hs_s        = aw_valid_q & axil.aw_ready;
    w_hs_s         = w_valid_q & axil.w_ready;
    tmo_hit_s      = TMO_EN && (tmo_q == TMO_LIMIT);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          wr_d      = cmd_write;
          addr_d    = cmd_addr;
          data_d    = cmd_data;
          mask_d    = cmd_mask;
          tmo_d     = 32'd0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_write) begin
            state_d    = S_WR;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
          end else begin
            state_d    = S_RD_A;
            ar_valid_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        // aw and w complete independently; a finished channel waits for the other.
        if (aw_hs_s) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end else begin
          aw_done_d = aw_done_q;
        end
        if (w_hs_s) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end else begin
          w_done_d = w_done_q;
        end
        if ((aw_done_q || aw_hs_s) && (w_done_q || w_hs_s)) begin
          state_d   = S_WR_B;
          b_ready_d = 1'b1;
          tmo_d     = 32'd0;
        end else if (tmo_hit_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR_B: begin
        if (axil.b_valid && b_ready_q) begin
          b_ready_d      = 1'b0;
          state_d        = S_RSP;
          rsp_valid_d    = 1'b1;
          rsp_write_d    = 1'b1;
          rsp_data_d     = data_q;
          rsp_resp_d     = axil.b_resp;
          rsp_mismatch_d = (axil.b_resp != 2'b00);
          rsp_timeout_d  = 1'b0;
        end else if (tmo_hit_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = S_WR_B;
        end
      end
      S_RD_A: begin
        if (ar_valid_q && axil.ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = S_RD_R;
          tmo_d      = 32'd0;
        end else if (tmo_hit_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = S_RD_A;
        end
      end
      S_RD_R: begin
        if (axil.r_valid && r_ready_q) begin
          r_ready_d      = 1'b0;
          state_d        = S_RSP;
          rsp_valid_d    = 1'b1;
          rsp_write_d    = 1'b0;
          rsp_data_d     = axil.r_data;
          rsp_resp_d     = axil.r_resp;
          rsp_mismatch_d = cmp_fail(axil.r_data, data_q, mask_q);
          rsp_timeout_d  = 1'b0;
        end else if (tmo_hit_s) begin
          abort_s = 1'b1;
        end else begin
          state_d = S_RD_R;
        end
      end
      S_RSP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_count_d = sat_inc(cmd_count_q);
          if (rsp_mismatch_q || rsp_timeout_q) begin
            err_count_d = sat_inc(err_count_q);
          end else begin
            err_count_d = err_count_q;
          end
          state_d = rsp_timeout_q ? S_HALT : S_IDLE;
        end else begin
          state_d = S_RSP;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A stalled channel abandons the transaction and reports it as a failed result.
    if (abort_s) begin
      aw_valid_d     = 1'b0;
      w_valid_d      = 1'b0;
      b_ready_d      = 1'b0;
      ar_valid_d     = 1'b0;
      r_ready_d      = 1'b0;
      state_d        = S_RSP;
      rsp_valid_d    = 1'b1;
      rsp_write_d    = wr_q;
      rsp_data_d     = wr_q ? data_q : {DATA_W{1'b0}};
      rsp_resp_d     = 2'b10;
      rsp_mismatch_d = 1'b1;
      rsp_timeout_d  = 1'b1;
    end else begin
      rsp_timeout_d  = rsp_timeout_d;
    end

    cmd_ready_d = (state_d == S_IDLE);
    halted_d    = (state_d == S_HALT);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wr_q           <= 1'b0;
      addr_q         <= {ADDR_W{1'b0}};
      data_q         <= {DATA_W{1'b0}};
      mask_q         <= {DATA_W{1'b0}};
      aw_done_q      <= 1'b0;
      w_done_q       <= 1'b0;
      tmo_q          <= 32'd0;
      cmd_ready_q    <= 1'b0;
      aw_valid_q     <= 1'b0;
      w_valid_q      <= 1'b0;
      b_ready_q      <= 1'b0;
      ar_valid_q     <= 1'b0;
      r_ready_q      <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_write_q    <= 1'b0;
      rsp_data_q     <= {DATA_W{1'b0}};
      rsp_resp_q     <= 2'b00;
      rsp_mismatch_q <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      cmd_count_q    <= {CNT_W{1'b0}};
      err_count_q    <= {CNT_W{1'b0}};
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_q           <= wr_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      mask_q         <= mask_d;
      aw_done_q      <= aw_done_d;
      w_done_q       <= w_done_d;
      tmo_q          <= tmo_d;
      cmd_ready_q    <= cmd_ready_d;
      aw_valid_q     <= aw_valid_d;
      w_valid_q      <= w_valid_d;
      b_ready_q      <= b_ready_d;
      ar_valid_q     <= ar_valid_d;
      r_ready_q      <= r_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_write_q    <= rsp_write_d;
      rsp_data_q     <= rsp_data_d;
      rsp_resp_q     <= rsp_resp_d;
      rsp_mismatch_q <= rsp_mismatch_d;
      rsp_timeout_q  <= rsp_timeout_d;
      cmd_count_q    <= cmd_count_d;
      err_count_q    <= err_count_d;
      halted_q       <= halted_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_mismatch  = rsp_mismatch_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign cmd_count     = cmd_count_q;
  assign err_count     = err_count_q;
  assign halted        = halted_q;
  assign axil.aw_addr  = addr_q;
  assign axil.aw_valid = aw_valid_q;
  assign axil.w_data   = data_q;
  assign axil.w_strb   = {STRB_W{1'b1}};
  assign axil.w_valid  = w_valid_q;
  assign axil.b_ready  = b_ready_q;
  assign axil.ar_addr  = addr_q;
  assign axil.ar_valid = ar_valid_q;
  assign axil.r_ready  = r_ready_q;
endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: the slave is driven step by step and
// every output is compared to hand-computed values with immediate assertions.
module tb_axil_cmd_master;
  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic [31:0] cmd_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        rsp_mismatch;
  logic        rsp_timeout;
  logic [15:0] cmd_count;
  logic [15:0] err_count;
  logic        halted;

  int checks = 0;
  int errors = 0;

  axil_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axil_cmd_master #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_mismatch(rsp_mismatch),
    .rsp_timeout(rsp_timeout), .axil(bus),
    .cmd_count(cmd_count), .err_count(err_count), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] m);
    chk("cmd_ready_before_send", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_mask  = m;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_data = 32'd0; cmd_mask = 32'd0;
    rsp_ready = 1'b0;
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0; bus.b_valid = 1'b0; bus.b_resp = 2'b00;
    bus.ar_ready = 1'b0; bus.r_valid = 1'b0; bus.r_data = 32'd0; bus.r_resp = 2'b00;
    tick();
    tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_aw_valid", 64'(bus.aw_valid), 64'd0);
    chk("rst_ar_valid", 64'(bus.ar_valid), 64'd0);
    chk("rst_w_strb", 64'(bus.w_strb), 64'hF);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_cmd_count", 64'(cmd_count), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Test 1: zero-wait write
    bus.aw_ready = 1'b1; bus.w_ready = 1'b1; bus.b_valid = 1'b1; bus.b_resp = 2'b00;
    rsp_ready = 1'b1;
    send(1'b1, 32'h10, 32'hDEADBEEF, 32'h0);
    chk("t1_aw_valid", 64'(bus.aw_valid), 64'd1);
    chk("t1_w_valid", 64'(bus.w_valid), 64'd1);
    chk("t1_aw_addr", 64'(bus.aw_addr), 64'h10);
    chk("t1_w_data", 64'(bus.w_data), 64'hDEADBEEF);
    chk("t1_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    tick();
    chk("t1_aw_drop", 64'(bus.aw_valid), 64'd0);
    chk("t1_w_drop", 64'(bus.w_valid), 64'd0);
    chk("t1_b_ready", 64'(bus.b_ready), 64'd1);
    tick();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1_rsp_write", 64'(rsp_write), 64'd1);
    chk("t1_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
    chk("t1_rsp_mismatch", 64'(rsp_mismatch), 64'd0);
    chk("t1_b_ready_drop", 64'(bus.b_ready), 64'd0);
    tick();
    chk("t1_rsp_done", 64'(rsp_valid), 64'd0);
    chk("t1_cmd_count", 64'(cmd_count), 64'd1);
    chk("t1_err_count", 64'(err_count), 64'd0);

    // Test 2: reads with matching, mismatching and masked data
    bus.ar_ready = 1'b1; bus.r_valid = 1'b1; bus.r_data = 32'hDEADBEEF; bus.r_resp = 2'b00;
    send(1'b0, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF);
    chk("t2a_ar_valid", 64'(bus.ar_valid), 64'd1);
    chk("t2a_ar_addr", 64'(bus.ar_addr), 64'h10);
    tick();
    chk("t2a_ar_drop", 64'(bus.ar_valid), 64'd0);
    chk("t2a_r_ready", 64'(bus.r_ready), 64'd1);
    tick();
    chk("t2a_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t2a_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
    chk("t2a_rsp_write", 64'(rsp_write), 64'd0);
    chk("t2a_mismatch", 64'(rsp_mismatch), 64'd0);
    tick();
    chk("t2a_cmd_count", 64'(cmd_count), 64'd2);

    bus.r_data = 32'hDEADBEEE;
    send(1'b0, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF);
    tick();
    tick();
    chk("t2b_rsp_data", 64'(rsp_data), 64'hDEADBEEE);
    chk("t2b_mismatch", 64'(rsp_mismatch), 64'd1);
    tick();
    chk("t2b_err_count", 64'(err_count), 64'd1);

    send(1'b0, 32'h10, 32'hDEADBEEF, 32'hFFFFFFF0);
    tick();
    tick();
    chk("t2c_mismatch", 64'(rsp_mismatch), 64'd0);
    tick();
    chk("t2c_cmd_count", 64'(cmd_count), 64'd4);
    chk("t2c_err_count", 64'(err_count), 64'd1);

    // Test 3: w accepted three cycles before aw
    bus.aw_ready = 1'b0; bus.w_ready = 1'b1;
    send(1'b1, 32'h20, 32'h12345678, 32'h0);
    tick();
    chk("t3_w_drop", 64'(bus.w_valid), 64'd0);
    chk("t3_aw_hold1", 64'(bus.aw_valid), 64'd1);
    chk("t3_b_wait1", 64'(bus.b_ready), 64'd0);
    tick();
    chk("t3_aw_hold2", 64'(bus.aw_valid), 64'd1);
    tick();
    chk("t3_aw_hold3", 64'(bus.aw_valid), 64'd1);
    chk("t3_b_wait3", 64'(bus.b_ready), 64'd0);
    chk("t3_rsp_none", 64'(rsp_valid), 64'd0);
    bus.aw_ready = 1'b1;
    tick();
    chk("t3_aw_drop", 64'(bus.aw_valid), 64'd0);
    chk("t3_b_ready", 64'(bus.b_ready), 64'd1);
    tick();
    chk("t3_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t3_rsp_data", 64'(rsp_data), 64'h12345678);
    chk("t3_mismatch", 64'(rsp_mismatch), 64'd0);
    tick();
    chk("t3_rsp_single", 64'(rsp_valid), 64'd0);
    chk("t3_cmd_count", 64'(cmd_count), 64'd5);

    // Test 4: SLVERR write with rsp_ready stalled for five cycles
    rsp_ready = 1'b0;
    bus.b_resp = 2'b10;
    send(1'b1, 32'h30, 32'hA5A5A5A5, 32'h0);
    tick();
    tick();
    chk("t4_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t4_rsp_resp", 64'(rsp_resp), 64'd2);
    chk("t4_mismatch", 64'(rsp_mismatch), 64'd1);
    cmd_valid = 1'b1; cmd_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t4_hold_data", 64'(rsp_data), 64'hA5A5A5A5);
      chk("t4_hold_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("t4_hold_no_ar", 64'(bus.ar_valid), 64'd0);
    end
    cmd_valid = 1'b0;
    bus.b_resp = 2'b00;
    rsp_ready = 1'b1;
    tick();
    chk("t4_rsp_done", 64'(rsp_valid), 64'd0);
    chk("t4_cmd_count", 64'(cmd_count), 64'd6);
    chk("t4_err_count", 64'(err_count), 64'd2);
    chk("t4_cmd_ready", 64'(cmd_ready), 64'd1);

    // Test 6: reset while aw_valid is high, then a normal read
    bus.aw_ready = 1'b0; bus.w_ready = 1'b0;
    send(1'b1, 32'h40, 32'h00000055, 32'h0);
    chk("t6_aw_valid", 64'(bus.aw_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_aw", 64'(bus.aw_valid), 64'd0);
    chk("t6_async_w", 64'(bus.w_valid), 64'd0);
    chk("t6_async_addr", 64'(bus.aw_addr), 64'd0);
    chk("t6_async_count", 64'(cmd_count), 64'd0);
    chk("t6_async_err", 64'(err_count), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    bus.r_data = 32'h0BADF00D;
    send(1'b0, 32'h44, 32'h0BADF00D, 32'hFFFFFFFF);
    tick();
    tick();
    chk("t6_rsp_data", 64'(rsp_data), 64'h0BADF00D);
    chk("t6_mismatch", 64'(rsp_mismatch), 64'd0);
    tick();
    chk("t6_cmd_count", 64'(cmd_count), 64'd1);

    // Test 5: ar_ready never arrives, timeout after 8 cycles then halt
    bus.ar_ready = 1'b0; bus.r_valid = 1'b0;
    send(1'b0, 32'h50, 32'h11111111, 32'hFFFFFFFF);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t5_ar_hold", 64'(bus.ar_valid), 64'd1);
    end
    tick();
    chk("t5_ar_drop", 64'(bus.ar_valid), 64'd0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t5_timeout", 64'(rsp_timeout), 64'd1);
    chk("t5_mismatch", 64'(rsp_mismatch), 64'd1);
    chk("t5_resp", 64'(rsp_resp), 64'd2);
    chk("t5_data", 64'(rsp_data), 64'd0);
    tick();
    chk("t5_halted", 64'(halted), 64'd1);
    chk("t5_cmd_count", 64'(cmd_count), 64'd2);
    chk("t5_err_count", 64'(err_count), 64'd1);
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_halt_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("t5_halt_ar", 64'(bus.ar_valid), 64'd0);
      chk("t5_halt_hold", 64'(halted), 64'd1);
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_halted", 64'(halted), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("t5_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Synthesizable AXI-Lite master that sits directly upstream of the banzAI AXI-Lite slave port and drives it.
- Consumes a stream of scripted commands {write/read, address, data, compare mask}, runs one AXI-Lite transaction per command, and checks read data against an expected value.
- Emits one result per command, plus saturating pass/fail counters.
- Replaces bench-only stimulus tasks, so register scripts can run on FPGA/emulation and feed the same slave.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width (STRB = DATA_W/8)
TIMEOUT, 1024, max cycles waited on any single AXI channel handshake; 0 disables
CNT_W, 16, width of the status counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_data  in  DATA_W  write data (write) / expected data (read)
cmd_mask  in  DATA_W  compare mask for reads; ignored on writes
rsp_valid  out  1  result valid
rsp_ready  in  1  result consumed when valid&ready
rsp_write  out  1  echo of cmd_write
rsp_data  out  DATA_W  r_data for reads, echoed write data for writes
rsp_resp  out  2  r_resp / b_resp
rsp_mismatch  out  1  read: ((r_data^expected)&mask)!=0; write: b_resp!=2'b00
rsp_timeout  out  1  transaction aborted by timeout
aw_addr, aw_valid, aw_ready; w_data, w_strb, w_valid, w_ready; b_resp, b_valid, b_ready; ar_addr, ar_valid, ar_ready; r_data, r_resp, r_valid, r_ready  AXI-Lite master side, standard directions/widths
cmd_count  out  CNT_W  commands completed, saturating
err_count  out  CNT_W  responses with mismatch or timeout, saturating
halted  out  1  block stopped after a timeout

Behaviour:
- Reset (async, immediate): state IDLE. All valid/ready outputs 0; addr/data outputs 0; w_strb all ones. rsp_* 0, counters 0, halted 0.
- FSM: IDLE, WR, WR_B, RD_A, RD_R, RSP, HALT. All outputs registered.
- IDLE: cmd_ready=1. On handshake, latch the command. Write -> WR (aw_valid=w_valid=1 next cycle). Read -> RD_A (ar_valid=1 next cycle).
- WR: aw and w are handshaked independently. Each valid drops the cycle after its own handshake. Same-cycle handshake of both is allowed. When both are done -> WR_B with b_ready=1.
- WR_B: on b_valid, capture b_resp; b_ready drops; go to RSP.
- RD_A: on ar_ready, drop ar_valid; r_ready=1; go to RD_R.
- RD_R: on r_valid, capture r_data/r_resp, compute mismatch; r_ready drops; go to RSP.
- Valids never drop before their handshake, except on timeout. Address/data stay stable while valid.
- RSP: rsp_valid=1, held stable until rsp_ready.
  - On handshake: cmd_count+1; err_count+1 if mismatch|timeout (both saturate at all ones).
  - Next state: HALT if timeout, else IDLE.
  - cmd_ready=0 in RSP, so there is one command in flight and no overlap.
- Minimum latency with zero-wait slave and rsp_ready=1:
  - read: cmd handshake T -> ar_valid T+1 -> r at T+2 -> rsp_valid T+3.
  - write: same (aw/w T+1, b T+2, rsp T+3).
- Timeout:
  - One cycle counter, cleared on entering each of WR, WR_B, RD_A, RD_R.
  - When it reaches TIMEOUT, deassert all AXI valid/ready and set rsp_timeout=1, rsp_mismatch=1, rsp_resp=2'b10; go to RSP.
  - In HALT: halted=1, cmd_ready=0; leave only via reset.
- rsp_data is 0 for a timed-out read.
- Reset mid-transaction: all AXI outputs drop immediately; the pending command is lost.

Test Plan:
1. Write 0x10 <- 0xDEADBEEF, slave OKAY, zero wait -> aw/w valid one cycle, rsp_valid 3 cycles after cmd; rsp_mismatch=0; cmd_count=1.
2. Read 0x10, expected 0xDEADBEEF, mask 0xFFFFFFFF, slave returns 0xDEADBEEF -> mismatch=0. Repeat with slave returning 0xDEADBEEE -> mismatch=1, err_count=1. Repeat with mask 0xFFFFFFF0 -> mismatch=0.
3. Slave asserts w_ready 3 cycles before aw_ready -> w_valid drops after its handshake while aw_valid is held; b_ready only after both are done; single rsp.
4. rsp_ready held 0 for 5 cycles -> rsp fields stable, cmd_ready=0, no new AXI activity; completes on release.
5. TIMEOUT=8, slave never asserts ar_ready -> ar_valid drops after 8 cycles; rsp_timeout=1, rsp_resp=2'b10; then halted=1, cmd_ready=0 until rst.
6. rst pulsed while aw_valid=1 -> all outputs return to reset values asynchronously; the next command runs normally with cmd_count starting from 0.
